processor_datapath: RTL and testbench

PROCESSOR_DATAPATH -- requirements
Module: processor_datapath

---
 rtl/processor_datapath.sv | 104 ++++++++++
 tb/tb_processor_datapath.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_datapath.sv
// Bus-based datapath for a simple multi-cycle processor: eight general registers,
// accumulator A, adder/subtractor result G, instruction register and a 2-bit time-step counter.
module processor_datapath #(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  r0_out,
  input  logic                  r1_out,
  input  logic                  r2_out,
  input  logic                  r3_out,
  input  logic                  r4_out,
  input  logic                  r5_out,
  input  logic                  r6_out,
  input  logic                  r7_out,
  input  logic                  g_out,
  input  logic                  din_out,
  input  logic                  r0_in,
  input  logic                  r1_in,
  input  logic                  r2_in,
  input  logic                  r3_in,
  input  logic                  r4_in,
  input  logic                  r5_in,
  input  logic                  r6_in,
  input  logic                  r7_in,
  input  logic                  a_in,
  input  logic                  g_in,
  input  logic                  ir_in,
  input  logic                  clr,
  output logic [1:0]            t,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] bus,
  output logic                  bus_err,
  input  logic [3:0]            dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] r_regs [8];
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_g;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [1:0]            r_t;

  logic [7:0]            w_reg_out;
  logic [7:0]            w_reg_in;
  logic [9:0]            w_src_sel;
  logic [DATA_WIDTH-1:0] w_bus;
  logic [DATA_WIDTH-1:0] w_alu;

  assign w_reg_out = {r7_out, r6_out, r5_out, r4_out, r3_out, r2_out, r1_out, r0_out};
  assign w_reg_in  = {r7_in, r6_in, r5_in, r4_in, r3_in, r2_in, r1_in, r0_in};
  assign w_src_sel = {din_out, g_out, w_reg_out};

  // Later assignments override earlier ones, so sources are visited lowest priority first.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_bus = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_reg_out[i]) w_bus = r_regs[i];
    end
    if (g_out)   w_bus = r_g;
    if (din_out) w_bus = din;
  end

  assign bus     = w_bus;
  assign bus_err = ($countones(w_src_sel) > 1);

  // r_ir here is the pre-edge value, so an IR load in the same cycle does not affect the op.
  assign w_alu = r_ir[6] ? (r_a - w_bus) : (r_a + w_bus);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the register file is small and must read 0 during reset, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      r_a  <= '0;
      r_g  <= '0;
      r_ir <= '0;
      r_t  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_reg_in[i]) r_regs[i] <= w_bus;
      end
      if (a_in)  r_a  <= w_bus;
      if (g_in)  r_g  <= w_alu;
      if (ir_in) r_ir <= w_bus;
      r_t <= clr ? 2'd0 : r_t + 2'd1;
    end
  end

  always_comb begin
    dbg_data = '0;
    case (dbg_sel)
      4'd8:    dbg_data = r_a;
      4'd9:    dbg_data = r_g;
      default: if (!dbg_sel[3]) dbg_data = r_regs[dbg_sel[2:0]];
    endcase
  end

  assign t  = r_t;
  assign ir = r_ir;

endmodule

// File: tb/tb_processor_datapath.sv
// Directed testbench for processor_datapath: reset, mvi, add, sub wrap, bus conflict,
// self-reload / multi-load, IR hazard and mid-instruction reset.
module tb_processor_datapath;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out;
  logic          g_out, din_out;
  logic          r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in;
  logic          a_in, g_in, ir_in, clr;
  logic [1:0]    t;
  logic [DW-1:0] ir;
  logic [DW-1:0] bus;
  logic          bus_err;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  int n_chk = 0;
  int n_bad = 0;

  processor_datapath #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .din(din),
    .r0_out(r0_out), .r1_out(r1_out), .r2_out(r2_out), .r3_out(r3_out),
    .r4_out(r4_out), .r5_out(r5_out), .r6_out(r6_out), .r7_out(r7_out),
    .g_out(g_out), .din_out(din_out),
    .r0_in(r0_in), .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in),
    .r4_in(r4_in), .r5_in(r5_in), .r6_in(r6_in), .r7_in(r7_in),
    .a_in(a_in), .g_in(g_in), .ir_in(ir_in), .clr(clr),
    .t(t), .ir(ir), .bus(bus), .bus_err(bus_err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic idle();
    {r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out} = '0;
    {r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in} = '0;
    {g_out, din_out, a_in, g_in, ir_in, clr} = '0;
    din = '0;
  endtask

  // One clock edge; returns 1 ns after it with all controls cleared.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic read_dbg(input logic [3:0] sel, output logic [DW-1:0] val);
    dbg_sel = sel;
    #1;
    val = dbg_data;
  endtask

  // Pulse reset in the high phase of the clock, well away from either edge.
  task automatic do_reset();
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    idle();
    dbg_sel = 4'd0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if (t !== 2'd0) begin n_bad++; $display("FAIL reset_t got=%0d exp=0", t); end
    chk("reset_ir", ir, '0);
    for (int s = 0; s < 10; s++) begin
      read_dbg(4'(s), v);
      chk($sformatf("reset_dbg%0d", s), v, '0);
    end
    din = 9'h0AB;
    din_out = 1'b1;
    #1;
    chk("reset_bus_din", bus, 9'h0AB);
    din_out = 1'b0;
    #1 rst = 1'b0;
    clk_run = 1'b1;
  endtask

  task automatic test_mvi();
    logic [DW-1:0] v;
    do_reset();
    din = 9'b001_010_000; ir_in = 1'b1; din_out = 1'b1;
    #1;
    n_chk++;
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL mvi_bus_err got=%0b exp=0", bus_err); end
    step();
    chk("mvi_ir", ir, 9'b001_010_000);
    n_chk++;
    if (t !== 2'd1) begin n_bad++; $display("FAIL mvi_t1 got=%0d exp=1", t); end
    din = 9'd37; din_out = 1'b1; r2_in = 1'b1; clr = 1'b1;
    step();
    read_dbg(4'd2, v);
    chk("mvi_r2", v, 9'd37);
    n_chk++;
    if (t !== 2'd0) begin n_bad++; $display("FAIL mvi_t_clr got=%0d exp=0", t); end
  endtask

  task automatic test_add();
    logic [DW-1:0] v;
    do_reset();
    din = 9'd100; din_out = 1'b1; r1_in = 1'b1;
    step();
    din = 9'd30; din_out = 1'b1; r3_in = 1'b1; clr = 1'b1;
    step();
    n_chk++;
    if (t !== 2'd0) begin n_bad++; $display("FAIL add_t0 got=%0d exp=0", t); end
    din = 9'b010_001_011; din_out = 1'b1; ir_in = 1'b1;
    step();
    n_chk++;
    if (t !== 2'd1) begin n_bad++; $display("FAIL add_t1 got=%0d exp=1", t); end
    a_in = 1'b1; r1_out = 1'b1;
    step();
    n_chk++;
    if (t !== 2'd2) begin n_bad++; $display("FAIL add_t2 got=%0d exp=2", t); end
    read_dbg(4'd8, v);
    chk("add_a", v, 9'd100);
    g_in = 1'b1; r3_out = 1'b1;
    step();
    n_chk++;
    if (t !== 2'd3) begin n_bad++; $display("FAIL add_t3 got=%0d exp=3", t); end
    read_dbg(4'd9, v);
    chk("add_g", v, 9'd130);
    g_out = 1'b1; r1_in = 1'b1; clr = 1'b1;
    #1;
    chk("add_bus_g", bus, 9'd130);
    step();
    read_dbg(4'd1, v);
    chk("add_r1", v, 9'd130);
    n_chk++;
    if (t !== 2'd0) begin n_bad++; $display("FAIL add_t_end got=%0d exp=0", t); end
  endtask

  task automatic test_sub_wrap();
    logic [DW-1:0] v;
    do_reset();
    din = 9'd5; din_out = 1'b1; a_in = 1'b1;
    step();
    din = 9'h040; din_out = 1'b1; ir_in = 1'b1;
    step();
    din = 9'd7; din_out = 1'b1; g_in = 1'b1;
    step();
    read_dbg(4'd9, v);
    chk("sub_wrap_g", v, 9'h1FE);
    din = 9'd511; din_out = 1'b1; a_in = 1'b1;
    step();
    din = 9'd0; din_out = 1'b1; ir_in = 1'b1;
    step();
    din = 9'd1; din_out = 1'b1; g_in = 1'b1;
    step();
    read_dbg(4'd9, v);
    chk("add_wrap_g", v, 9'd0);
    // IR switches to sub in the same cycle G loads: pre-edge IR (add) must be used.
    din = 9'h040; din_out = 1'b1; g_in = 1'b1; ir_in = 1'b1;
    step();
    read_dbg(4'd9, v);
    chk("ir_hazard_g", v, 9'd63);
    chk("ir_hazard_ir", ir, 9'h040);
  endtask

  task automatic test_conflict();
    logic [DW-1:0] v;
    do_reset();
    din = 9'd200; din_out = 1'b1; r4_in = 1'b1;
    step();
    din = 9'd10; din_out = 1'b1; a_in = 1'b1;
    step();
    din = 9'd20; din_out = 1'b1; g_in = 1'b1;
    step();
    r4_out = 1'b1; g_out = 1'b1;
    #1;
    chk("conf_bus_g", bus, 9'd30);
    n_chk++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL conf_err got=%0b exp=1", bus_err); end
    g_out = 1'b0;
    #1;
    chk("single_bus_r4", bus, 9'd200);
    n_chk++;
    if (bus_err !== 1'b0) begin n_bad++; $display("FAIL single_err got=%0b exp=0", bus_err); end
    r4_out = 1'b0; r7_out = 1'b1; din_out = 1'b1; din = 9'd77;
    #1;
    chk("conf_bus_din", bus, 9'd77);
    n_chk++;
    if (bus_err !== 1'b1) begin n_bad++; $display("FAIL conf_err2 got=%0b exp=1", bus_err); end
    idle();
    #1;
    chk("nosrc_bus", bus, '0);
    // Self reload plus multiple targets from one bus value.
    r4_out = 1'b1; r4_in = 1'b1; r5_in = 1'b1; r6_in = 1'b1;
    step();
    read_dbg(4'd4, v);
    chk("self_r4", v, 9'd200);
    read_dbg(4'd5, v);
    chk("multi_r5", v, 9'd200);
    read_dbg(4'd6, v);
    chk("multi_r6", v, 9'd200);
    read_dbg(4'd12, v);
    chk("dbg_unused", v, '0);
  endtask

  task automatic test_midop_reset();
    logic [DW-1:0] v;
    do_reset();
    din = 9'd50; din_out = 1'b1; a_in = 1'b1;
    step();
    din = 9'd7; din_out = 1'b1; g_in = 1'b1; clr = 1'b1;
    step();
    din = 9'd100; din_out = 1'b1; r1_in = 1'b1;
    step();
    din = 9'd30; din_out = 1'b1; r3_in = 1'b1; clr = 1'b1;
    step();
    din = 9'b010_001_011; din_out = 1'b1; ir_in = 1'b1;
    step();
    a_in = 1'b1; r1_out = 1'b1;
    step();
    n_chk++;
    if (t !== 2'd2) begin n_bad++; $display("FAIL mid_t2 got=%0d exp=2", t); end
    read_dbg(4'd9, v);
    chk("mid_g_pre", v, 9'd57);
    g_in = 1'b1; r3_out = 1'b1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (t !== 2'd0) begin n_bad++; $display("FAIL mid_t_rst got=%0d exp=0", t); end
    read_dbg(4'd9, v);
    chk("mid_g_rst", v, '0);
    read_dbg(4'd8, v);
    chk("mid_a_rst", v, '0);
    idle();
    rst = 1'b0;
    step();
    n_chk++;
    if (t !== 2'd1) begin n_bad++; $display("FAIL mid_first_edge got=%0d exp=1", t); end
    step();
    read_dbg(4'd1, v);
    chk("mid_r1_after", v, '0);
    read_dbg(4'd9, v);
    chk("mid_g_after", v, '0);
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_add();
    test_sub_wrap();
    test_conflict();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
